// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the AXI4 read DMA engine.
// Feature macro AXI_DMA_RD_ERR_EN (see axi_dma_rd_engine) uses the response enum below.
package axi_dma_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } rd_state_e;

  localparam int unsigned BOUNDARY_4K = 4096;
  localparam logic [3:0]  AR_CACHE    = 4'b0011;

endpackage

// File: rtl/axi_dma_burst_calc.sv
// Burst sizing: beats = min(remaining, max burst, beats left before the next 4 KB boundary).
module axi_dma_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int LEN_WIDTH     = 9,
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0]          i_addr_lo,
  input  logic [LEN_WIDTH-1:0] i_rem,
  output logic [8:0]           o_beats
);

  localparam int SHIFT = $clog2(STRB_WIDTH);
  localparam int CW    = (LEN_WIDTH > 14) ? LEN_WIDTH : 14;

  logic [CW-1:0] w_rem;
  logic [CW-1:0] w_gap;
  logic [CW-1:0] w_max;
  logic [CW-1:0] w_min;

  assign w_rem = CW'(i_rem);
  assign w_gap = CW'((BOUNDARY_4K - 32'(i_addr_lo)) >> SHIFT);
  assign w_max = CW'(MAX_BURST_LEN);

  always_comb begin
    w_min = w_rem;
    if (w_max < w_min) w_min = w_max;
    if (w_gap < w_min) w_min = w_gap;
  end

  // Result never exceeds MAX_BURST_LEN (<= 256), so 9 bits always hold it.
  assign o_beats = 9'(w_min);

endmodule

// File: rtl/axi_dma_rd_engine.sv
// AXI4 read DMA master: one descriptor -> INCR bursts on AR/R, data returned as AXI-Stream.
// Optional macro AXI_DMA_RD_ERR_EN adds a sticky read-response error status output.
//
// state   | meaning
// IDLE    | desc_ready high, waiting for a descriptor
// ADDR    | drive one AR burst, hold stable until arready
// DATA    | pass R beats to the stream until rlast
// DONE    | one-cycle status pulse, then back to IDLE
module axi_dma_rd_engine
  import axi_dma_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int LEN_WIDTH      = 9,
  parameter int MAX_BURST_LEN  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axis_read_desc_addr,
  input  logic [LEN_WIDTH-1:0]      s_axis_read_desc_len,
  input  logic                      s_axis_read_desc_valid,
  output logic                      s_axis_read_desc_ready,
  output logic                      m_axis_read_desc_status_valid,
`ifdef AXI_DMA_RD_ERR_EN
  output logic [1:0]                m_axis_read_desc_status_error,
`endif
  output logic [AXI_DATA_WIDTH-1:0] m_axis_read_data_tdata,
  output logic                      m_axis_read_data_tvalid,
  input  logic                      m_axis_read_data_tready,
  output logic                      m_axis_read_data_tlast,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int SHIFT = $clog2(AXI_STRB_WIDTH);

  rd_state_e                 r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]      r_rem;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                r_arlen;
  logic [8:0]                r_burst;
  logic                      r_arvalid;
  logic                      r_desc_ready;
  logic                      r_status_valid;
  logic [1:0]                r_err;

  logic [8:0]                w_beats;
  logic [LEN_WIDTH-1:0]      w_desc_beats;
  logic                      w_in_data;
  logic                      w_r_fire;
  logic                      w_unused;

  axi_dma_burst_calc #(
    .LEN_WIDTH    (LEN_WIDTH),
    .STRB_WIDTH   (AXI_STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_calc (
    .i_addr_lo(r_addr[11:0]),
    .i_rem    (r_rem),
    .o_beats  (w_beats)
  );

  assign w_desc_beats = s_axis_read_desc_len >> SHIFT;
  assign w_in_data    = (r_state == ST_DATA);
  assign w_r_fire     = w_in_data && m_axi_rvalid && m_axis_read_data_tready;

  // R channel is a zero-latency pass-through; r_rem already excludes the current burst.
  assign m_axi_rready            = w_in_data && m_axis_read_data_tready;
  assign m_axis_read_data_tvalid = w_in_data && m_axi_rvalid;
  assign m_axis_read_data_tdata  = m_axi_rdata;
  assign m_axis_read_data_tlast  = w_in_data && m_axi_rlast && (r_rem == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_rem          <= '0;
      r_araddr       <= '0;
      r_arlen        <= '0;
      r_burst        <= '0;
      r_arvalid      <= 1'b0;
      r_desc_ready   <= 1'b1;
      r_status_valid <= 1'b0;
      r_err          <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_axis_read_desc_valid && r_desc_ready) begin
            r_addr       <= s_axis_read_desc_addr & ~AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1);
            r_rem        <= w_desc_beats;
            r_desc_ready <= 1'b0;
            r_err        <= 2'b00;
            if (w_desc_beats == '0) begin
              r_state        <= ST_DONE;
              r_status_valid <= 1'b1;
            end else begin
              r_state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // First ADDR cycle loads the AR registers; they stay frozen until arready.
          if (!r_arvalid) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_beats - 9'd1);
            r_burst   <= w_beats;
          end else if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_addr    <= r_addr + (AXI_ADDR_WIDTH'(r_burst) << SHIFT);
            r_rem     <= r_rem - LEN_WIDTH'(r_burst);
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_fire) begin
            if ((r_err == RESP_OKAY) && (m_axi_rresp != RESP_OKAY)) r_err <= m_axi_rresp;
            if (m_axi_rlast) begin
              if (r_rem != '0) begin
                r_state <= ST_ADDR;
              end else begin
                r_state        <= ST_DONE;
                r_status_valid <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          r_status_valid <= 1'b0;
          r_desc_ready   <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_read_desc_ready        = r_desc_ready;
  assign m_axis_read_desc_status_valid = r_status_valid;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = 3'(SHIFT);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AR_CACHE;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;

`ifdef AXI_DMA_RD_ERR_EN
  assign m_axis_read_desc_status_error = r_err;
  assign w_unused = ^m_axi_rid;
`else
  assign w_unused = ^{m_axi_rid, r_err};
`endif

endmodule

// File: tb/tb_axi_dma_rd_engine.sv
// Scoreboard bench for axi_dma_rd_engine with a randomized AXI4 RAM slave.
// Build with AXI_DMA_RD_ERR_EN defined to also exercise the error-status output.
module tb_axi_dma_rd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_read_desc_addr = '0;
  logic [8:0]  s_axis_read_desc_len = '0;
  logic        s_axis_read_desc_valid = 1'b0;
  logic        s_axis_read_desc_ready;
  logic        m_axis_read_desc_status_valid;
`ifdef AXI_DMA_RD_ERR_EN
  logic [1:0]  m_axis_read_desc_status_error;
`endif
  logic [31:0] m_axis_read_data_tdata;
  logic        m_axis_read_data_tvalid;
  logic        m_axis_read_data_tready = 1'b1;
  logic        m_axis_read_data_tlast;
  logic [7:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [7:0]  m_axi_rid = '0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  axi_dma_rd_engine dut (
    .clk                          (clk),
    .rst                          (rst),
    .s_axis_read_desc_addr        (s_axis_read_desc_addr),
    .s_axis_read_desc_len         (s_axis_read_desc_len),
    .s_axis_read_desc_valid       (s_axis_read_desc_valid),
    .s_axis_read_desc_ready       (s_axis_read_desc_ready),
    .m_axis_read_desc_status_valid(m_axis_read_desc_status_valid),
`ifdef AXI_DMA_RD_ERR_EN
    .m_axis_read_desc_status_error(m_axis_read_desc_status_error),
`endif
    .m_axis_read_data_tdata       (m_axis_read_data_tdata),
    .m_axis_read_data_tvalid      (m_axis_read_data_tvalid),
    .m_axis_read_data_tready      (m_axis_read_data_tready),
    .m_axis_read_data_tlast       (m_axis_read_data_tlast),
    .m_axi_arid                   (m_axi_arid),
    .m_axi_araddr                 (m_axi_araddr),
    .m_axi_arlen                  (m_axi_arlen),
    .m_axi_arsize                 (m_axi_arsize),
    .m_axi_arburst                (m_axi_arburst),
    .m_axi_arlock                 (m_axi_arlock),
    .m_axi_arcache                (m_axi_arcache),
    .m_axi_arprot                 (m_axi_arprot),
    .m_axi_arvalid                (m_axi_arvalid),
    .m_axi_arready                (m_axi_arready),
    .m_axi_rid                    (m_axi_rid),
    .m_axi_rdata                  (m_axi_rdata),
    .m_axi_rresp                  (m_axi_rresp),
    .m_axi_rlast                  (m_axi_rlast),
    .m_axi_rvalid                 (m_axi_rvalid),
    .m_axi_rready                 (m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;
  typedef struct { int beats; logic [1:0] err; } st_t;

  int      n_checks = 0;
  int      n_pass = 0;
  longint  cyc = 0;
  ar_t     exp_ar[$];
  beat_t   exp_beat[$];
  st_t     exp_st[$];
  ar_t     ar_log[$];
  logic [31:0] mem [0:4095];
  int      err_word = -1;
  int      tready_mode = 0;
  int      beat_cnt = 0;
  longint  last_beat_cyc = 0;
  logic    prev_status = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: split a descriptor into bursts from the transfer rules.
  function automatic void model_push(input logic [31:0] addr, input logic [8:0] len);
    int a, nb, rem, b, gap, w;
    logic [1:0] err;
    a = int'(addr) & ~3;
    nb = int'(len) / 4;
    rem = nb;
    err = 2'b00;
    while (rem > 0) begin
      gap = (4096 - (a % 4096)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > gap) b = gap;
      exp_ar.push_back('{32'(a), 8'(b - 1)});
      for (int k = 0; k < b; k++) begin
        w = ((a / 4) + k) % 4096;
        exp_beat.push_back('{mem[w], (rem == b) && (k == b - 1)});
        if (err == 2'b00 && w == err_word) err = 2'b10;
      end
      a += 4 * b;
      rem -= b;
    end
    exp_st.push_back('{nb, err});
  endfunction

  // AXI4 RAM slave with random arready / rvalid gaps.
  ar_t sl_q[$];
  int  sl_idx = 0;
  initial begin
    bit  ar_hs, r_hs;
    ar_t ar_cap;
    int  w;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      ar_cap = '{m_axi_araddr, m_axi_arlen};
      r_hs = m_axi_rvalid && m_axi_rready;
      @(posedge clk);
      #1;
      if (rst) begin
        sl_q.delete();
        sl_idx = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        continue;
      end
      if (ar_hs) sl_q.push_back(ar_cap);
      if (r_hs && sl_q.size() > 0) begin
        m_axi_rvalid = 1'b0;
        if (sl_idx == int'(sl_q[0].len)) begin
          void'(sl_q.pop_front());
          sl_idx = 0;
        end else begin
          sl_idx++;
        end
      end
      m_axi_arready = ($urandom_range(0, 2) != 0);
      if (!m_axi_rvalid && sl_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        w = ((int'(sl_q[0].addr) / 4) + sl_idx) % 4096;
        m_axi_rdata = mem[w];
        m_axi_rresp = (w == err_word) ? 2'b10 : 2'b00;
        m_axi_rlast = (sl_idx == int'(sl_q[0].len));
        m_axi_rvalid = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: m_axis_read_data_tready = 1'b1;
        1: m_axis_read_data_tready = ~m_axis_read_data_tready;
        default: m_axis_read_data_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  always @(negedge clk) begin
    ar_t   ea;
    beat_t eb;
    st_t   es;
    if (!rst) begin
      if (m_axi_arvalid && m_axi_arready) begin
        ar_log.push_back('{m_axi_araddr, m_axi_arlen});
        chk("ar_expected", exp_ar.size() > 0, 1);
        if (exp_ar.size() > 0) begin
          ea = exp_ar.pop_front();
          chk("ar_addr", m_axi_araddr, ea.addr);
          chk("ar_len", m_axi_arlen, ea.len);
        end
      end
      if (m_axis_read_data_tvalid && m_axis_read_data_tready) begin
        beat_cnt++;
        chk("beat_expected", exp_beat.size() > 0, 1);
        if (exp_beat.size() > 0) begin
          eb = exp_beat.pop_front();
          chk("tdata", m_axis_read_data_tdata, eb.data);
          chk("tlast", m_axis_read_data_tlast, eb.last);
        end
        if (m_axis_read_data_tlast) last_beat_cyc = cyc;
      end
      if (m_axi_rvalid) chk("rready_mirror", m_axi_rready, m_axis_read_data_tready);
      if (sl_q.size() > 0) chk("no_ar_in_data", m_axi_arvalid, 0);
      if (m_axis_read_desc_status_valid) begin
        chk("status_pulse_width", prev_status, 0);
        chk("status_expected", exp_st.size() > 0, 1);
        if (exp_st.size() > 0) begin
          es = exp_st.pop_front();
          if (es.beats > 0) chk("status_latency", cyc - last_beat_cyc, 1);
`ifdef AXI_DMA_RD_ERR_EN
          chk("status_error", m_axis_read_desc_status_error, es.err);
`endif
        end
      end
      prev_status = m_axis_read_desc_status_valid;
    end else begin
      prev_status = 1'b0;
    end
  end

  task automatic send_desc(input logic [31:0] a, input logic [8:0] l);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    s_axis_read_desc_addr = a;
    s_axis_read_desc_len = l;
    s_axis_read_desc_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_read_desc_ready || t > 2000) break;
      t++;
    end
    chk("desc_accept_in_time", s_axis_read_desc_ready, 1);
    model_push(a, l);
    @(posedge clk);
    #1;
    s_axis_read_desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      done = (exp_ar.size() == 0) && (exp_beat.size() == 0) && (exp_st.size() == 0);
    end
    chk("done_in_time", done, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, n0;
    logic [31:0] ra;
    for (int i = 0; i < 4096; i++) mem[i] = {16'($urandom), 16'(i)};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_desc_ready", s_axis_read_desc_ready, 1);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_tvalid", m_axis_read_data_tvalid, 0);
    chk("rst_status", m_axis_read_desc_status_valid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("arsize", m_axi_arsize, 2);
    chk("arburst", m_axi_arburst, 1);
    chk("arcache", m_axi_arcache, 3);
    chk("arid_lock_prot", {m_axi_arid, m_axi_arlock, m_axi_arprot}, 0);
    @(negedge clk);
    rst = 1'b0;

    // addr 8, 80 bytes: split at the 16-beat limit; busy descriptors are ignored
    tready_mode = 0;
    ar_log.delete();
    send_desc(32'h8, 9'd80);
    s_axis_read_desc_addr = 32'h400;
    s_axis_read_desc_len = 9'd40;
    s_axis_read_desc_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("busy_desc_ready", s_axis_read_desc_ready, 0);
    end
    s_axis_read_desc_valid = 1'b0;
    wait_idle();
    chk("t1_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t1_ar0", {ar_log[0].addr, ar_log[0].len}, {32'h8, 8'd15});
      chk("t1_ar1", {ar_log[1].addr, ar_log[1].len}, {32'h48, 8'd3});
    end

    // 4 KB boundary split
    ar_log.delete();
    send_desc(32'hFF8, 9'd16);
    wait_idle();
    chk("t2_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t2_ar0", {ar_log[0].addr, ar_log[0].len}, {32'hFF8, 8'd1});
      chk("t2_ar1", {ar_log[1].addr, ar_log[1].len}, {32'h1000, 8'd1});
    end

    // zero-beat descriptors: status only, no AR traffic
    foreach (ar_log[i]) ar_log.delete(i);
    ar_log.delete();
    for (int z = 0; z < 2; z++) begin
      send_desc(32'h40, (z == 0) ? 9'd0 : 9'd3);
      k = 1;
      while (!m_axis_read_desc_status_valid && k < 6) begin
        @(negedge clk);
        k++;
      end
      chk("len0_status_latency_ok", k <= 2, 1);
      wait_idle();
    end
    chk("len0_no_ar", ar_log.size(), 0);

    // tready toggling every cycle
    tready_mode = 1;
    send_desc(32'h0, 9'd64);
    wait_idle();

    // reset during the second beat of a 16-beat burst
    tready_mode = 0;
    base = beat_cnt;
    send_desc(32'h0, 9'd64);
    for (int i = 0; i < 2000 && beat_cnt < base + 2; i++) @(negedge clk);
    chk("reached_beat2", beat_cnt >= base + 2, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_arvalid", m_axi_arvalid, 0);
    chk("midrst_tvalid", m_axis_read_data_tvalid, 0);
    chk("midrst_status", m_axis_read_desc_status_valid, 0);
    chk("midrst_desc_ready", s_axis_read_desc_ready, 1);
    exp_ar.delete();
    exp_beat.delete();
    exp_st.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_desc(32'h100, 9'd40);
    wait_idle();

`ifdef AXI_DMA_RD_ERR_EN
    err_word = (32'h200 / 4) + 2;
    send_desc(32'h200, 9'd32);
    wait_idle();
    chk("err_sticky", m_axis_read_desc_status_error, 2'b10);
    err_word = -1;
`endif

    // randomized descriptors
    n0 = 0;
    for (int r = 0; r < 40; r++) begin
      tready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        ra = 32'h1000 - 4 * $urandom_range(0, 24) + ($urandom_range(0, 1) * 32'h1000);
      else
        ra = $urandom_range(0, 32'h1E00);
      ra = ra + $urandom_range(0, 3);
      send_desc(ra, ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(0, 511)));
      wait_idle();
      n0++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
